// File: rtl/qspi_mem_responder_pkg.sv
// Shared constants for the QSPI memory responder: FSM state encodings, bus opcodes and phase lengths.
package qspi_mem_responder_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_MODE   = 3'd3;
  localparam logic [2:0] ST_DUMMY  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_WDATA  = 3'd6;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] CMD_WRITE      = 8'h02;
  localparam logic [7:0] CMD_QREAD_CONT = 8'hEB;
  localparam logic [1:0] MODE_CONT      = 2'b10;

  localparam logic [2:0] ADDR_NIBBLES = 3'd6;

endpackage

// File: rtl/qspi_mem_responder_sync.sv
// Brings the asynchronous QSPI bus into the clk domain and derives edge pulses
// for the bus clock and chip select; data shares the clock's sync depth so samples line up.
module qspi_resp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qspi_clk,
  input  logic       qspi_cs_n,
  input  logic [3:0] qspi_data_in,
  output logic [3:0] o_data,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_cs_start,
  output logic       o_cs_end
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_cs_sync;
  logic [3:0] r_data_meta;
  logic [3:0] r_data_sync;
  logic       r_clk_d;
  logic       r_cs_d;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_data_meta <= 4'h0;
      r_data_sync <= 4'h0;
      r_clk_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], qspi_clk};
      r_cs_sync   <= {r_cs_sync[0], qspi_cs_n};
      r_data_meta <= qspi_data_in;
      r_data_sync <= r_data_meta;
      r_clk_d     <= r_clk_sync[1];
      r_cs_d      <= r_cs_sync[1];
    end
  end

  assign o_data     = r_data_sync;
  assign o_rise     = r_clk_sync[1] & ~r_clk_d;
  assign o_fall     = ~r_clk_sync[1] & r_clk_d;
  assign o_cs_start = ~r_cs_sync[1] & r_cs_d;
  assign o_cs_end   = r_cs_sync[1] & ~r_cs_d;

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI memory target for tinyQV emulation: decodes quad read (0x0B) / write (0x02) and serves a byte memory port.
// Continuous quad read (0xEB + mode byte) is built in only when QSPI_RESP_CONT_READ_EN is defined.
module qspi_mem_responder
  import qspi_mem_responder_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              qspi_clk,
  input  logic              qspi_cs_n,
  input  logic [3:0]        qspi_data_in,
  output logic [3:0]        qspi_data_out,
  output logic [3:0]        qspi_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  logic [3:0]  w_data;
  logic        w_rise;
  logic        w_fall;
  logic        w_cs_start;
  logic        w_cs_end;
  logic [23:0] w_addr_full;

  logic [2:0]  r_state;
  logic [2:0]  r_nib_cnt;
  logic [3:0]  r_nib;
  logic [3:0]  r_dummy_cnt;
  logic [19:0] r_addr_sh;
  logic        r_write;
  logic        r_lo_next;
  logic        r_re_pend;
  logic [7:0]  r_rd_byte;
`ifdef QSPI_RESP_CONT_READ_EN
  logic        r_xip;
  logic        r_cont;
`endif

  qspi_resp_sync u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .qspi_clk     (qspi_clk),
    .qspi_cs_n    (qspi_cs_n),
    .qspi_data_in (qspi_data_in),
    .o_data       (w_data),
    .o_rise       (w_rise),
    .o_fall       (w_fall),
    .o_cs_start   (w_cs_start),
    .o_cs_end     (w_cs_end)
  );

  assign w_addr_full = {r_addr_sh, w_data};

  // Transaction FSM, memory strobes and bus drive; the read byte lands one clk after each mem_re
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_nib_cnt     <= 3'd0;
      r_nib         <= 4'h0;
      r_dummy_cnt   <= 4'h0;
      r_addr_sh     <= 20'h0;
      r_write       <= 1'b0;
      r_lo_next     <= 1'b0;
      r_re_pend     <= 1'b0;
      r_rd_byte     <= 8'h00;
      qspi_data_out <= 4'h0;
      qspi_data_oe  <= 4'h0;
      mem_addr      <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= 8'h00;
`ifdef QSPI_RESP_CONT_READ_EN
      r_xip         <= 1'b0;
      r_cont        <= 1'b0;
`endif
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      r_re_pend <= mem_re;
      if (r_re_pend) begin
        r_rd_byte <= mem_rdata;
      end
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (w_cs_end) begin
        r_state       <= ST_IDLE;
        qspi_data_oe  <= 4'h0;
        qspi_data_out <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_start) begin
              r_nib_cnt <= 3'd0;
              r_lo_next <= 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
              if (r_cont) begin
                r_state <= ST_ADDR;
                r_write <= 1'b0;
                r_xip   <= 1'b1;
              end else begin
                r_state <= ST_CMD;
              end
`else
              r_state <= ST_CMD;
`endif
            end
          end
          ST_CMD: begin
            if (w_rise) begin
              r_nib     <= w_data;
              r_nib_cnt <= r_nib_cnt + 3'd1;
              if (r_nib_cnt == 3'd1) begin
                r_nib_cnt <= 3'd0;
                case ({r_nib, w_data})
                  CMD_READ: begin
                    r_state <= ST_ADDR;
                    r_write <= 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
                    r_xip   <= 1'b0;
`endif
                  end
                  CMD_WRITE: begin
                    r_state <= ST_ADDR;
                    r_write <= 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
                    r_xip   <= 1'b0;
`endif
                  end
`ifdef QSPI_RESP_CONT_READ_EN
                  CMD_QREAD_CONT: begin
                    r_state <= ST_ADDR;
                    r_write <= 1'b0;
                    r_xip   <= 1'b1;
                  end
`endif
                  default: r_state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_addr_sh <= {r_addr_sh[15:0], w_data};
              r_nib_cnt <= r_nib_cnt + 3'd1;
              if (r_nib_cnt == (ADDR_NIBBLES - 3'd1)) begin
                r_nib_cnt   <= 3'd0;
                r_dummy_cnt <= 4'h0;
                mem_addr    <= w_addr_full[ADDR_W-1:0];
                if (r_write) begin
                  r_state <= ST_WDATA;
                end else begin
                  mem_re  <= 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
                  r_state <= r_xip ? ST_MODE : ST_DUMMY;
`else
                  r_state <= ST_DUMMY;
`endif
                end
              end
            end
          end
`ifdef QSPI_RESP_CONT_READ_EN
          // mode[5:4] are the low two bits of the first (high) mode nibble
          ST_MODE: begin
            if (w_rise) begin
              r_nib     <= w_data;
              r_nib_cnt <= r_nib_cnt + 3'd1;
              if (r_nib_cnt == 3'd1) begin
                r_nib_cnt <= 3'd0;
                r_cont    <= (r_nib[1:0] == MODE_CONT);
                r_state   <= ST_DUMMY;
              end
            end
          end
`endif
          ST_DUMMY: begin
            if (w_rise) begin
              if (r_dummy_cnt == DUMMY_LAST) begin
                r_state   <= ST_RDATA;
                r_lo_next <= 1'b0;
              end else begin
                r_dummy_cnt <= r_dummy_cnt + 4'h1;
              end
            end
          end
          ST_RDATA: begin
            if (w_fall) begin
              qspi_data_oe <= 4'hF;
              r_lo_next    <= ~r_lo_next;
              if (r_lo_next) begin
                qspi_data_out <= r_rd_byte[3:0];
                mem_addr      <= mem_addr + ADDR_W'(1);
                mem_re        <= 1'b1;
              end else begin
                qspi_data_out <= r_rd_byte[7:4];
              end
            end
          end
          ST_WDATA: begin
            if (w_rise) begin
              r_nib     <= w_data;
              r_lo_next <= ~r_lo_next;
              if (r_lo_next) begin
                mem_we    <= 1'b1;
                mem_wdata <= {r_nib, w_data};
              end
            end
          end
          ST_IGNORE: r_state <= ST_IGNORE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Scoreboard bench: a QSPI controller model pushes expected strobes/nibbles; monitors pop and compare.
module tb_qspi_mem_responder;

  localparam int HP = 80;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        qclk  = 1'b0;
  logic        qcs_n = 1'b1;
  logic [3:0]  qdin  = 4'h0;

  logic [3:0]  qdout, qoe, qdout8, qoe8;
  logic [23:0] mem_addr;
  logic [7:0]  mem_addr8;
  logic        mem_re, mem_we, mem_re8, mem_we8;
  logic [7:0]  mem_wdata, mem_wdata8;
  logic [7:0]  rdata, rdata8;

  logic [7:0]  mem [0:1023];
  logic [23:0] q_re[$];
  logic [31:0] q_we[$];
  logic [3:0]  q_nib[$];
  logic [7:0]  log8[$];
  logic        arm8 = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  qspi_mem_responder #(.ADDR_W(24), .DUMMY_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk), .qspi_cs_n(qcs_n), .qspi_data_in(qdin),
    .qspi_data_out(qdout), .qspi_data_oe(qoe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  qspi_mem_responder #(.ADDR_W(8), .DUMMY_CYCLES(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk), .qspi_cs_n(qcs_n), .qspi_data_in(qdin),
    .qspi_data_out(qdout8), .qspi_data_oe(qoe8), .mem_addr(mem_addr8), .mem_re(mem_re8),
    .mem_rdata(rdata8), .mem_we(mem_we8), .mem_wdata(mem_wdata8)
  );

  always @(posedge clk) begin
    if (mem_re) rdata <= mem[mem_addr[9:0]];
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re8) rdata8 <= mem[{2'b00, mem_addr8}];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  // Memory-port monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re && mem_we) unexpected("re_we_both", {8'h0, mem_addr});
      if (mem_re) begin
        if (q_re.size() == 0) unexpected("mem_re", {8'h0, mem_addr});
        else check("mem_re_addr", {8'h0, mem_addr}, {8'h0, q_re.pop_front()});
      end
      if (mem_we) begin
        if (q_we.size() == 0) unexpected("mem_we", {mem_addr, mem_wdata});
        else check("mem_we_addr_data", {mem_addr, mem_wdata}, q_we.pop_front());
      end
      if (mem_re8 && arm8) log8.push_back(mem_addr8);
    end
  end

  // Bus monitor: the controller samples read data on its rising edge
  always @(posedge qclk) begin
    if (rst_n && !qcs_n && qoe != 4'h0) begin
      if (q_nib.size() == 0) unexpected("bus_oe", {24'h0, qoe, qdout});
      else check("rd_nibble", {24'h0, qoe, qdout}, {24'h0, 4'hF, q_nib.pop_front()});
    end
  end

  task automatic cs_low();
    qcs_n = 1'b0;
    #HP;
  endtask

  task automatic cs_high();
    #HP;
    qcs_n = 1'b1;
    #(3*HP);
  endtask

  task automatic nib(input logic [3:0] n);
    qdin = n;
    #HP;
    qclk = 1'b1;
    #HP;
    qclk = 1'b0;
  endtask

  task automatic clocks(input int k);
    for (int i = 0; i < k; i++) nib(4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
  endtask

  task automatic drain(input string tag);
    check({tag, "_re_left"}, q_re.size(), 32'd0);
    check({tag, "_we_left"}, q_we.size(), 32'd0);
    check({tag, "_nib_left"}, q_nib.size(), 32'd0);
  endtask

  task automatic push_nibs(input logic [7:0] b);
    q_nib.push_back(b[7:4]);
    q_nib.push_back(b[3:0]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    mem[16] <= 8'h11; mem[17] <= 8'h22; mem[18] <= 8'h33; mem[19] <= 8'h44;
    mem[32] <= 8'h5C; mem[48] <= 8'hA5; mem[64] <= 8'h7E; mem[80] <= 8'h96;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_oe", {28'h0, qoe}, 32'h0);
    check("rst_dout", {28'h0, qdout}, 32'h0);
    check("rst_re", {31'h0, mem_re}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_wdata", {24'h0, mem_wdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #(2*HP);

    // Reset during the data phase of a read
    q_re.push_back(24'h000030); q_re.push_back(24'h000031);
    push_nibs(8'hA5);
    cs_low(); send_byte(8'h0B); send_addr(24'h000030); clocks(4); clocks(2);
    #40;
    check("oe_before_reset", {28'h0, qoe}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("oe_in_reset", {28'h0, qoe}, 32'h0);
    check("re_in_reset", {31'h0, mem_re}, 32'h0);
    qcs_n = 1'b1;
    #(HP-1);
    rst_n = 1'b1;
    #(2*HP);
    drain("rst_read");

    // Clean 4-byte read after the reset
    for (int a = 16; a <= 20; a++) q_re.push_back(24'(a));
    push_nibs(8'h11); push_nibs(8'h22); push_nibs(8'h33); push_nibs(8'h44);
    cs_low(); send_byte(8'h0B); send_addr(24'h000010); clocks(4); clocks(8);
    #HP;
    check("oe_before_cs_rise", {28'h0, qoe}, 32'hF);
    qcs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_after_cs_rise", {28'h0, qoe}, 32'h0);
    check("dout_after_cs_rise", {28'h0, qdout}, 32'h0);
    @(negedge clk);
    #(2*HP);
    drain("read");

    // Two-byte write crossing 0xFF -> 0x100
    q_we.push_back({24'h0000FF, 8'hAB}); q_we.push_back({24'h000100, 8'hCD});
    cs_low(); send_byte(8'h02); send_addr(24'h0000FF); send_byte(8'hAB); send_byte(8'hCD); cs_high();
    drain("write");

    // Wrap: the 8-bit instance must step 0xFF -> 0x00
    log8.delete();
    arm8 = 1'b1;
    q_re.push_back(24'h0000FF); q_re.push_back(24'h000100); q_re.push_back(24'h000101);
    push_nibs(8'hAB); push_nibs(8'hCD);
    cs_low(); send_byte(8'h0B); send_addr(24'h0000FF); clocks(4); clocks(4); cs_high();
    arm8 = 1'b0;
    check("wrap_count", log8.size(), 32'd3);
    if (log8.size() >= 2) begin
      check("wrap_addr0", {24'h0, log8[0]}, 32'hFF);
      check("wrap_addr1", {24'h0, log8[1]}, 32'h00);
    end else begin
      unexpected("wrap_short", log8.size());
    end
    drain("wrap");

    // Abort after three write nibbles: only the first byte lands
    q_we.push_back({24'h000200, 8'h12});
    cs_low(); send_byte(8'h02); send_addr(24'h000200); nib(4'h1); nib(4'h2); nib(4'h3); cs_high();
    drain("abort");

    // Unknown command is ignored until deselect
    cs_low(); send_byte(8'h9F); send_addr(24'h000010); clocks(8); cs_high();
    drain("unknown");

`ifdef QSPI_RESP_CONT_READ_EN
    q_re.push_back(24'h000020); q_re.push_back(24'h000021); push_nibs(8'h5C);
    cs_low(); send_byte(8'hEB); send_addr(24'h000020); send_byte(8'hA0); clocks(4); clocks(2); cs_high();
    drain("cont_first");
    q_re.push_back(24'h000040); q_re.push_back(24'h000041); push_nibs(8'h7E);
    cs_low(); send_addr(24'h000040); send_byte(8'hFF); clocks(4); clocks(2); cs_high();
    drain("cont_skip_cmd");
`else
    cs_low(); send_byte(8'hEB); send_addr(24'h000020); send_byte(8'hA0); clocks(4); clocks(2); cs_high();
    drain("eb_ignored");
`endif

    // Plain read must decode its first byte as a command again
    q_re.push_back(24'h000050); q_re.push_back(24'h000051); push_nibs(8'h96);
    cs_low(); send_byte(8'h0B); send_addr(24'h000050); clocks(4); clocks(2); cs_high();
    drain("cmd_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
